// File: rtl/hashin_deframer.sv
// Reassembles framed 64-bit hashin words plus a nonce into a 640-bit block header
// for the hash core, with framing resync, nonce consistency checks and a stop/flush handshake.
module hashin_deframer #(
    parameter logic [63:0] HDR_WORD = 64'h8000000000000280,
    parameter int          NWORDS   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           hashin_fifo_dout,
    input  logic                  hashin_fifo_empty,
    output logic                  hashin_fifo_rd_en,
    input  logic [31:0]           nonce_fifo_dout,
    input  logic                  nonce_fifo_empty,
    output logic                  nonce_fifo_rd_en,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic [NWORDS*64-1:0]  msg_data,
    output logic [31:0]           msg_nonce,
    output logic                  msg_nonce_mismatch,
    input  logic                  stop,
    output logic                  stop_ack,
    output logic [15:0]           frame_err_cnt,
    output logic [15:0]           nonce_err_cnt
);

    localparam int CW = $clog2(NWORDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, NONCE, OUT, FLUSH} state_t;

    state_t        state, next_state;
    logic [CW-1:0] word_cnt;
    logic          hdr_match;
    logic          fifos_empty;
    logic [31:0]   nonce_swapped;

    assign hdr_match     = (hashin_fifo_dout == HDR_WORD);
    assign fifos_empty   = hashin_fifo_empty && nonce_fifo_empty;
    assign nonce_swapped = {nonce_fifo_dout[7:0], nonce_fifo_dout[15:8],
                            nonce_fifo_dout[23:16], nonce_fifo_dout[31:24]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (stop) begin
                    next_state = FLUSH;
                end else if (hashin_fifo_rd_en && hdr_match) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    next_state = FLUSH;
                end else if (hashin_fifo_rd_en && word_cnt == CW'(NWORDS - 1)) begin
                    next_state = NONCE;
                end
            end
            NONCE: begin
                if (stop) begin
                    next_state = FLUSH;
                end else if (nonce_fifo_rd_en) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                // A transfer in the same cycle as stop still completes before flushing.
                if (msg_ready) begin
                    next_state = stop ? FLUSH : IDLE;
                end else if (stop) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (!stop && fifos_empty) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        hashin_fifo_rd_en = 1'b0;
        nonce_fifo_rd_en  = 1'b0;
        case (state)
            IDLE, LOAD: hashin_fifo_rd_en = !stop && !hashin_fifo_empty;
            NONCE:      nonce_fifo_rd_en  = !stop && !nonce_fifo_empty;
            FLUSH: begin
                hashin_fifo_rd_en = !hashin_fifo_empty;
                nonce_fifo_rd_en  = !nonce_fifo_empty;
            end
            default: ;
        endcase
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt           <= '0;
            msg_valid          <= 1'b0;
            msg_data           <= '0;
            msg_nonce          <= '0;
            msg_nonce_mismatch <= 1'b0;
            stop_ack           <= 1'b0;
            frame_err_cnt      <= '0;
            nonce_err_cnt      <= '0;
        end else begin
            msg_valid <= (next_state == OUT);
            stop_ack  <= (state == FLUSH) && (next_state == FLUSH) && fifos_empty;

            if (state == IDLE && hashin_fifo_rd_en) begin
                if (hdr_match) begin
                    word_cnt <= '0;
                end else if (frame_err_cnt != 16'hFFFF) begin
                    frame_err_cnt <= frame_err_cnt + 16'd1;
                end
            end

            if (state == LOAD && hashin_fifo_rd_en) begin
                msg_data <= {msg_data[NWORDS*64-65:0], hashin_fifo_dout};
                word_cnt <= word_cnt + CW'(1);
            end

            if (state == NONCE && nonce_fifo_rd_en) begin
                msg_nonce          <= nonce_fifo_dout;
                msg_nonce_mismatch <= (msg_data[31:0] != nonce_swapped);
                if (msg_data[31:0] != nonce_swapped && nonce_err_cnt != 16'hFFFF) begin
                    nonce_err_cnt <= nonce_err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hashin_deframer.sv
// Scoreboard bench for hashin_deframer: queue-modelled FWFT FIFOs feed the DUT,
// expected headers are queued at stimulus time and compared on every valid cycle.
module tb_hashin_deframer;

    localparam logic [63:0] HDR = 64'h8000000000000280;

    typedef struct {
        logic [639:0] data;
        logic [31:0]  nonce;
        logic         mism;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  hashin_fifo_dout = '0;
    logic         hashin_fifo_empty = 1'b1;
    logic         hashin_fifo_rd_en;
    logic [31:0]  nonce_fifo_dout = '0;
    logic         nonce_fifo_empty = 1'b1;
    logic         nonce_fifo_rd_en;
    logic         msg_valid;
    logic         msg_ready = 1'b1;
    logic [639:0] msg_data;
    logic [31:0]  msg_nonce;
    logic         msg_nonce_mismatch;
    logic         stop = 1'b0;
    logic         stop_ack;
    logic [15:0]  frame_err_cnt;
    logic [15:0]  nonce_err_cnt;

    logic [63:0]  hq[$];
    logic [31:0]  nq[$];
    exp_t         exp_q[$];
    int           rise_q[$];
    logic [63:0]  frame_words[10];

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int last_hdr = 0;
    int hpush = 0, hpop = 0, npush = 0, npop = 0;
    logic valid_prev = 1'b0;

    hashin_deframer dut (
        .clk                (clk),
        .rst                (rst),
        .hashin_fifo_dout   (hashin_fifo_dout),
        .hashin_fifo_empty  (hashin_fifo_empty),
        .hashin_fifo_rd_en  (hashin_fifo_rd_en),
        .nonce_fifo_dout    (nonce_fifo_dout),
        .nonce_fifo_empty   (nonce_fifo_empty),
        .nonce_fifo_rd_en   (nonce_fifo_rd_en),
        .msg_valid          (msg_valid),
        .msg_ready          (msg_ready),
        .msg_data           (msg_data),
        .msg_nonce          (msg_nonce),
        .msg_nonce_mismatch (msg_nonce_mismatch),
        .stop               (stop),
        .stop_ack           (stop_ack),
        .frame_err_cnt      (frame_err_cnt),
        .nonce_err_cnt      (nonce_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [639:0] got, input logic [639:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

    // FIFO model: pops at the clock edge, head/empty refreshed at the falling edge.
    always @(posedge clk) begin
        if (!rst && hashin_fifo_rd_en) begin
            check_output("hashin_pop_nonempty", hashin_fifo_empty, 0);
            if (hq.size() > 0) begin
                if (hq[0] == HDR) last_hdr = cycle;
                void'(hq.pop_front());
                hpop++;
            end
        end
        if (!rst && nonce_fifo_rd_en) begin
            check_output("nonce_pop_nonempty", nonce_fifo_empty, 0);
            if (nq.size() > 0) begin
                void'(nq.pop_front());
                npop++;
            end
        end
        cycle++;
    end

    always @(negedge clk) begin
        hashin_fifo_empty = (hq.size() == 0);
        hashin_fifo_dout  = hashin_fifo_empty ? 64'h0 : hq[0];
        nonce_fifo_empty  = (nq.size() == 0);
        nonce_fifo_dout   = nonce_fifo_empty ? 32'h0 : nq[0];
    end

    // Output monitor: every valid cycle is compared to the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (msg_valid) begin
                if (!valid_prev) rise_q.push_back(cycle);
                if (exp_q.size() == 0) begin
                    check_output("spurious_valid", msg_valid, 0);
                end else begin
                    if (!valid_prev && exp_q[0].lat >= 0)
                        check_output("latency", cycle - last_hdr, exp_q[0].lat);
                    check_output("msg_data", msg_data, exp_q[0].data);
                    check_output("msg_nonce", msg_nonce, exp_q[0].nonce);
                    check_output("mismatch_flag", msg_nonce_mismatch, exp_q[0].mism);
                    if (msg_ready) void'(exp_q.pop_front());
                end
            end
            valid_prev = msg_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_frame(input logic [31:0] w9lo, input logic [31:0] nonce,
                               input int lat, input bit expect_out);
        logic [639:0] d;
        exp_t e;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            frame_words[i] = {$urandom, $urandom};
            if (i == 9) frame_words[i][31:0] = w9lo;
            d = {d[575:0], frame_words[i]};
        end
        nq.push_back(nonce);
        npush++;
        if (expect_out) begin
            e.data  = d;
            e.nonce = nonce;
            e.mism  = (d[31:0] != bswap(nonce));
            e.lat   = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_words(input bit with_hdr, input int from, input int to);
        if (with_hdr) begin
            hq.push_back(HDR);
            hpush++;
        end
        for (int i = from; i <= to; i++) begin
            hq.push_back(frame_words[i]);
            hpush++;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] w9lo, input logic [31:0] nonce);
        build_frame(w9lo, nonce, 12, 1'b1);
        push_words(1'b1, 0, 9);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 400 && !(exp_q.size() == 0 && hq.size() == 0 && nq.size() == 0)) begin
            tick(1);
            i++;
        end
        check_output("drain_in_time", (i < 400), 1);
        tick(2);
        check_output("hashin_pops", hpop, hpush);
        check_output("nonce_pops", npop, npush);
    endtask

    initial begin
        int i;
        tick(3);
        check_output("rst_valid", msg_valid, 0);
        check_output("rst_stop_ack", stop_ack, 0);
        check_output("rst_data", msg_data, 0);
        check_output("rst_nonce", msg_nonce, 0);
        check_output("rst_mismatch", msg_nonce_mismatch, 0);
        check_output("rst_frame_err", frame_err_cnt, 0);
        check_output("rst_nonce_err", nonce_err_cnt, 0);
        rst = 1'b0;
        tick(2);

        $display("[TB] single frame, matching nonce");
        apply_stimulus(32'h78563412, 32'h12345678);
        wait_idle();
        check_output("nonce_err_after_good", nonce_err_cnt, 0);

        $display("[TB] single frame, mismatching nonce");
        apply_stimulus(32'h78563412, 32'h12345679);
        wait_idle();
        check_output("nonce_err_after_bad", nonce_err_cnt, 1);

        $display("[TB] garbage words before frame");
        for (int k = 0; k < 3; k++) begin
            hq.push_back(64'h0);
            hpush++;
        end
        apply_stimulus(32'h78563412, 32'h12345678);
        wait_idle();
        check_output("frame_err_cnt", frame_err_cnt, 3);

        $display("[TB] hashin stall and delayed ready");
        msg_ready = 1'b0;
        build_frame(32'h78563412, 32'h12345678, 16, 1'b1);
        push_words(1'b1, 0, 5);
        i = 0;
        do begin
            tick(1);
            i++;
        end while (hq.size() != 0 && i < 100);
        tick(4);
        push_words(1'b0, 6, 9);
        i = 0;
        while (!msg_valid && i < 100) begin
            tick(1);
            i++;
        end
        check_output("stall_valid_seen", msg_valid, 1);
        tick(2);
        msg_ready = 1'b1;
        wait_idle();

        $display("[TB] stop mid-frame");
        build_frame(32'h78563412, 32'h12345678, -1, 1'b0);
        nq.push_back(32'hDEADBEEF);
        npush++;
        push_words(1'b1, 0, 9);
        begin
            int h0;
            h0 = hpop;
            i = 0;
            while (hpop - h0 < 5 && i < 100) begin
                tick(1);
                i++;
            end
        end
        stop = 1'b1;
        i = 0;
        while (!stop_ack && i < 100) begin
            tick(1);
            i++;
        end
        check_output("stop_ack_high", stop_ack, 1);
        check_output("flush_hashin_left", hq.size(), 0);
        check_output("flush_nonce_left", nq.size(), 0);
        stop = 1'b0;
        tick(3);
        check_output("stop_ack_low", stop_ack, 0);
        apply_stimulus(32'h78563412, 32'h12345678);
        wait_idle();

        $display("[TB] back-to-back frames");
        rise_q.delete();
        build_frame(32'h78563412, 32'h12345678, 12, 1'b1);
        push_words(1'b1, 0, 9);
        build_frame(32'h44332211, 32'h11223344, 12, 1'b1);
        push_words(1'b1, 0, 9);
        wait_idle();
        check_output("b2b_valid_count", rise_q.size(), 2);
        if (rise_q.size() >= 2) check_output("b2b_spacing", rise_q[1] - rise_q[0], 13);
        check_output("nonce_err_final", nonce_err_cnt, 1);

        $display("[TB] reset mid-frame");
        build_frame(32'h78563412, 32'h12345678, -1, 1'b0);
        void'(nq.pop_back());
        npush--;
        push_words(1'b1, 0, 2);
        tick(6);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_output("mid_rst_frame_err", frame_err_cnt, 0);
        check_output("mid_rst_nonce_err", nonce_err_cnt, 0);
        check_output("mid_rst_valid", msg_valid, 0);
        apply_stimulus(32'h78563412, 32'h12345678);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
